interval_meter: RTL
===================

# interval_meter

Measures the number of clock cycles between a start event and a stop event and presents the result on a valid/ready output. It is the measuring counterpart to the countdown timer: the timer produces an interval of N cycles from `start_i` to `done_o`, and this block recovers N. Typical uses are loop-back checks of timer instances, pulse-width measurement and latency probes.

## Interface
- `WIDTH`, default 8: width of the measured count; results saturate at 2^WIDTH-1.
- `clk_i` input 1: clock; all logic is on the rising edge.
- `rst_ni` input 1: reset, synchronous, active-low.
- `start_i` input 1: start event, sampled on each rising edge.
- `stop_i` input 1: stop event, sampled on each rising edge.
- `ready_i` input 1: consumer accepts the result when `valid_o && ready_i`.
- `count_o` output WIDTH: measured interval in cycles; stable while `valid_o`.
- `overflow_o` output 1: interval exceeded 2^WIDTH-1; qualified by `valid_o`.
- `valid_o` output 1: a result is held on `count_o`/`overflow_o`.
- `busy_o` output 1: a measurement is in progress (RUNNING state).

## Operation
- States: IDLE, RUNNING, RESULT. Internal counter `cnt` is WIDTH bits with a sticky saturation flag `sat`.
- IDLE:
  - `start_i=1` moves to RUNNING, with `cnt<=0` and `sat<=0`.
  - `stop_i` alone is ignored.
- RUNNING:
  - `stop_i=1` moves to RESULT.
    - `count_o <= cnt+1`, saturating at all-ones.
    - `overflow_o <= sat | (cnt==all-ones)`.
  - `stop_i` has priority over `start_i` in the same cycle; that `start_i` is dropped.
  - `start_i=1` without `stop_i` restarts: `cnt<=0`, `sat<=0`, stay in RUNNING. The previous measurement is discarded.
  - Otherwise, if `cnt` is all-ones then `sat<=1` and `cnt` holds; else `cnt<=cnt+1`.
- RESULT:
  - `valid_o=1`. `count_o` and `overflow_o` are held unchanged until accepted.
  - `valid_o && ready_i` with `start_i=1` moves directly to RUNNING (`cnt<=0`, `sat<=0`). This allows back-to-back measurements.
  - `valid_o && ready_i` with `start_i=0` moves to IDLE.
  - `start_i` without `ready_i` is ignored (no loss of a held result). `stop_i` is ignored.
- Reset (`rst_ni=0` at an edge) applies in any state, including mid-measurement and with a pending result.
  - State returns to IDLE, `cnt=0`, `sat=0`, `count_o=0`, `overflow_o=0`, `valid_o=0`, `busy_o=0`.
  - Any result or measurement in progress is lost.
- Arithmetic: `cnt+1` is evaluated WIDTH+1 bits wide and clamped to 2^WIDTH-1.

## Timing
- Reset values: `count_o=0`, `overflow_o=0`, `valid_o=0`, `busy_o=0`.
- Measurement definition:
  - `start_i` sampled at edge k and `stop_i` sampled at edge k+N give `count_o=N`.
  - Minimum measurable interval is N=1.
  - This equals the timer's programmed count when `start_i` is driven by the timer's start and `stop_i` by the first cycle of the timer's `done_o`.
- `busy_o` rises after edge k and falls after the stop edge.
- `valid_o` rises after the stop edge, i.e. the cycle after `stop_i` is seen. Result latency is 1 cycle.
- `valid_o` falls after the accepting edge, unless that edge also started a new measurement; in that case `busy_o` rises on the same edge.
- Saturation: for N ≥ 2^WIDTH, `count_o=2^WIDTH-1` and `overflow_o=1`. For N = 2^WIDTH-1 exactly, `overflow_o=0`.
- Throughput: one measurement per N+1 cycles minimum when `ready_i` is held high and start coincides with acceptance.

## Test plan
- WIDTH=8: reset, then `start_i` at edge 10 and `stop_i` at edge 35 → `valid_o` high from cycle 36, `count_o=25`, `overflow_o=0`, `busy_o` high between the edges.
- Start then stop on the next edge, with `ready_i=1` → `count_o=1`, `valid_o` high for exactly 1 cycle, return to IDLE.
- Saturation boundaries:
  - N=255 → `count_o=255`, `overflow_o=0`.
  - N=256 → `count_o=255`, `overflow_o=1`.
  - N=1000 → `count_o=255`, `overflow_o=1`.
- Hold `ready_i=0` for 20 cycles after a result of 7 while pulsing `start_i`/`stop_i` → `count_o` stays 7 and `valid_o` stays 1. Raising `ready_i` with `start_i=1` restarts; a stop 4 edges later gives `count_o=4`.
- Restart and collision rules:
  - Start, a second `start_i` 5 edges later, then `stop_i` 3 edges after that → `count_o=3`.
  - Start and stop asserted together while RUNNING → stop wins, and the result counts from the original start.
- `rst_ni=0` for one edge mid-RUNNING, and separately while RESULT is pending → all outputs 0 the next cycle. A later `stop_i` alone produces no result.

Source files
------------

// File: rtl/interval_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : interval_meter_if
//  Description : Handshake bundle for interval_meter. Carries the start/stop
//                event inputs, the result valid/ready handshake and the
//                measurement outputs.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    start_i    : start event, sampled every rising edge
//    stop_i     : stop event, sampled every rising edge
//    ready_i    : consumer accepts the result when valid_o && ready_i
//    count_o    : measured interval in cycles (WIDTH bits, saturating)
//    overflow_o : interval exceeded 2^WIDTH-1, qualified by valid_o
//    valid_o    : a result is held on count_o / overflow_o
//    busy_o     : a measurement is in progress
//  Modports
//    master     : the stimulus / consumer side
//    slave      : the meter itself
// ============================================================================
interface interval_meter_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic             stop_i;
    logic             ready_i;
    logic [WIDTH-1:0] count_o;
    logic             overflow_o;
    logic             valid_o;
    logic             busy_o;

    modport master (
        output start_i,
        output stop_i,
        output ready_i,
        input  count_o,
        input  overflow_o,
        input  valid_o,
        input  busy_o
    );

    modport slave (
        input  start_i,
        input  stop_i,
        input  ready_i,
        output count_o,
        output overflow_o,
        output valid_o,
        output busy_o
    );
endinterface
`default_nettype wire

// File: rtl/interval_meter.sv
`default_nettype none
// ============================================================================
//  Module      : interval_meter
//  Description : Counts the clock cycles between a start event and a stop
//                event and presents the result on a valid/ready output.
//                A start sampled at edge k and a stop sampled at edge k+N
//                produce count_o = N (minimum N = 1). Results saturate at
//                2^WIDTH-1 with overflow_o flagging intervals that did not fit.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i  : clock, all logic on the rising edge
//    rst_ni : synchronous active-low reset
//    bus    : interval_meter_if.slave (start/stop events, result handshake,
//             count/overflow/valid/busy outputs)
//  Parameters
//    WIDTH  : width of the measured count
// ============================================================================
module interval_meter #(
    parameter int WIDTH = 8
) (
    input  wire logic         clk_i,
    input  wire logic         rst_ni,
    interval_meter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        RESULT  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    state_t           state;
    logic [WIDTH-1:0] cnt;          // cycles seen since start, minus one
    logic             sat;          // sticky: cnt has tried to pass CNT_MAX
    logic [WIDTH-1:0] count;
    logic             overflow;
    logic             valid;
    logic             busy;

    // cnt+1 evaluated one bit wider so the carry shows saturation.
    logic [WIDTH:0]   cnt_inc;
    logic [WIDTH-1:0] cnt_inc_sat;
    logic             cnt_at_max;

    always_comb begin
        cnt_inc     = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
        cnt_inc_sat = cnt_inc[WIDTH] ? CNT_MAX : cnt_inc[WIDTH-1:0];
        cnt_at_max  = (cnt == CNT_MAX);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cnt      <= '0;
            sat      <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A lone stop has nothing to terminate and is ignored.
                    if (bus.start_i) begin
                        state <= RUNNING;
                        cnt   <= '0;
                        sat   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end

                RUNNING: begin
                    if (bus.stop_i) begin
                        // Stop wins over a coincident start; that start is
                        // dropped and the result counts from the original one.
                        state    <= RESULT;
                        count    <= cnt_inc_sat;
                        overflow <= sat | cnt_at_max;
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                    end else if (bus.start_i) begin
                        // Restart: the measurement so far is discarded.
                        cnt <= '0;
                        sat <= 1'b0;
                    end else if (cnt_at_max) begin
                        sat <= 1'b1;
                    end else begin
                        cnt <= cnt_inc[WIDTH-1:0];
                    end
                end

                RESULT: begin
                    // count/overflow hold until accepted; start without ready
                    // and stop are ignored so a held result is never lost.
                    if (bus.ready_i) begin
                        valid <= 1'b0;
                        if (bus.start_i) begin
                            // Accept and start on the same edge for
                            // back-to-back measurements.
                            state <= RUNNING;
                            cnt   <= '0;
                            sat   <= 1'b0;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count_o    = count;
    assign bus.overflow_o = overflow;
    assign bus.valid_o    = valid;
    assign bus.busy_o     = busy;

endmodule
`default_nettype wire
